// File: rtl/mcs4_timing_pkg.sv
// Shared MCS-4 instruction timing definitions: subcycle phase codes and
// the sync-decoder lock states. Used by both the CPU-side phase generator
// and the peripheral-side sync decoder.
package mcs4_timing_pkg;

    // Subcycle phase codes, in bus order.
    localparam logic [2:0] PH_A1 = 3'd0;
    localparam logic [2:0] PH_A2 = 3'd1;
    localparam logic [2:0] PH_A3 = 3'd2;
    localparam logic [2:0] PH_M1 = 3'd3;
    localparam logic [2:0] PH_M2 = 3'd4;
    localparam logic [2:0] PH_X1 = 3'd5;
    localparam logic [2:0] PH_X2 = 3'd6;
    localparam logic [2:0] PH_X3 = 3'd7;

    // Sync decoder lock states.
    localparam logic [0:0] ST_HUNT   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    // One-hot strobe vector for a phase code; bit index equals phase code.
    function automatic logic [7:0] phase_onehot(input logic [2:0] ph);
        phase_onehot = 8'b0000_0001 << ph;
    endfunction

endpackage

// File: rtl/mcs4_clk_edge.sv
// clk1 rising-boundary detector. The history register comes out of reset
// high so a clk1 that is already high at reset release is not mistaken
// for a new subcycle.
module mcs4_clk_edge (
    input  logic sysclk,
    input  logic reset,
    input  logic clk1,
    output logic boundary
);

    logic clk1_d;

    // Registered copy of clk1, forced high while in reset.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            clk1_d <= 1'b1;
        end else begin
            clk1_d <= clk1;
        end
    end

    assign boundary = clk1 & ~clk1_d;

endmodule

// File: rtl/mcs4_sync_decoder.sv
// Peripheral-side MCS-4 sync decoder. Rebuilds the eight-subcycle
// instruction timing (A1..X3) from clk1/clk2 and the CPU SYNC strobe,
// and reports lock status and SYNC timing violations.
module mcs4_sync_decoder
    import mcs4_timing_pkg::*;
#(
    parameter int MISS_LIMIT = 2
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       clk1,
    input  logic       clk2,
    input  logic       sync,
    output logic       a1,
    output logic       a2,
    output logic       a3,
    output logic       m1,
    output logic       m2,
    output logic       x1,
    output logic       x2,
    output logic       x3,
    output logic [2:0] phase,
    output logic       locked,
    output logic       sync_err
);

    localparam logic [3:0] MISS_LIM = 4'(MISS_LIMIT);

    logic       boundary;
    logic       sync_q;
    logic       sync_seen;
    logic [0:0] state;
    logic [0:0] state_nx;
    logic [2:0] phase_r;
    logic [2:0] phase_nx;
    logic [2:0] miss_cnt;
    logic [2:0] miss_nx;
    logic [3:0] miss_inc;
    logic       err_nx;
    logic [7:0] strobe_r;
    logic [7:0] strobe_nx;

    mcs4_clk_edge u_clk_edge (
        .sysclk   (sysclk),
        .reset    (reset),
        .clk1     (clk1),
        .boundary (boundary)
    );

    // SYNC only counts while clk2 is low.
    assign sync_q   = sync & ~clk2;
    assign miss_inc = {1'b0, miss_cnt} + 4'd1;

    // Sticky SYNC flag; a boundary consumes it, and a qualified sample on
    // the boundary edge itself belongs to the subcycle that is starting.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            sync_seen <= 1'b0;
        end else if (boundary) begin
            sync_seen <= sync_q;
        end else if (sync_q) begin
            sync_seen <= 1'b1;
        end
    end

    // Next-state decision, evaluated only on a clk1 boundary.
    always_comb begin
        state_nx = state;
        phase_nx = phase_r;
        miss_nx  = miss_cnt;
        err_nx   = 1'b0;
        if (boundary) begin
            case (state)
                ST_HUNT: begin
                    if (sync_seen) begin
                        state_nx = ST_LOCKED;
                        phase_nx = PH_A1;
                        miss_nx  = 3'd0;
                    end
                end
                default: begin
                    if (sync_seen) begin
                        // Normal realignment at X3, or early SYNC anywhere else.
                        err_nx   = (phase_r != PH_X3);
                        phase_nx = PH_A1;
                        miss_nx  = 3'd0;
                    end else if (phase_r != PH_X3) begin
                        phase_nx = phase_r + 3'd1;
                    end else begin
                        // Expected SYNC did not arrive during X3.
                        err_nx = 1'b1;
                        if (miss_inc >= MISS_LIM) begin
                            state_nx = ST_HUNT;
                            phase_nx = PH_A1;
                            miss_nx  = 3'd0;
                        end else begin
                            phase_nx = PH_A1;
                            miss_nx  = miss_inc[2:0];
                        end
                    end
                end
            endcase
        end
        strobe_nx = (state_nx == ST_LOCKED) ? phase_onehot(phase_nx) : 8'd0;
    end

    // Lock state, phase, miss counter and registered outputs.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state    <= ST_HUNT;
            phase_r  <= PH_A1;
            miss_cnt <= 3'd0;
            strobe_r <= 8'd0;
            sync_err <= 1'b0;
        end else begin
            state    <= state_nx;
            phase_r  <= phase_nx;
            miss_cnt <= miss_nx;
            strobe_r <= strobe_nx;
            sync_err <= err_nx;
        end
    end

    assign {x3, x2, x1, m2, m1, a3, a2, a1} = strobe_r;
    assign phase  = phase_r;
    assign locked = (state == ST_LOCKED);

endmodule
